// File: rtl/gpu_loader_pkg.sv
// Shared types and constants for the gpu program loader.
// The optional checksum feature is enabled by defining GPU_LOADER_CHECKSUM_EN.
package gpu_loader_pkg;

  localparam int unsigned DefaultDataDepth = 1024;
  localparam int unsigned WordW            = 16;

  typedef logic [WordW-1:0] xsum_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StZero,
    StHold,
    StDone
  } loader_state_e;

  function automatic xsum_t xsum_fold(input xsum_t acc, input xsum_t word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/gpu_loader_xsum.sv
// Running XOR accumulator over payload words; only used when GPU_LOADER_CHECKSUM_EN is defined.
module gpu_loader_xsum
  import gpu_loader_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  clr_i,
  input  logic  en_i,
  input  xsum_t data_i,
  output xsum_t sum_o
);

  xsum_t sum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (en_i) begin
      sum_q <= xsum_fold(sum_q, data_i);
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/gpu_prog_loader.sv
// Streams a program into a flat DataDepth x 16 frame, zero-fills the tail and holds the gpu in
// load until the frame has settled. Optional trailing checksum word: GPU_LOADER_CHECKSUM_EN.
module gpu_prog_loader
  import gpu_loader_pkg::*;
#(
  parameter int unsigned DataDepth  = DefaultDataDepth,
  parameter int unsigned HoldCycles = 4,
  localparam int unsigned Aw        = $clog2(DataDepth)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           load_start_i,
  input  logic [Aw:0]                    load_len_i,
  input  logic                           in_valid_i,
  input  logic [WordW-1:0]               in_data_i,
  output logic                           in_ready_o,
  output logic [DataDepth-1:0][WordW-1:0] data_frames_out_o,
  output logic                           prog_loading_o,
  output logic                           load_done_o,
  output logic                           load_err_o
);

  localparam int unsigned HcW      = $clog2(HoldCycles + 1);
  localparam logic [Aw:0]    LenMax   = (Aw + 1)'(DataDepth);
  localparam logic [Aw:0]    LenOne   = (Aw + 1)'(1);
  localparam logic [Aw-1:0]  PtrMax   = Aw'(DataDepth - 1);
  localparam logic [HcW-1:0] HoldLast = HcW'(HoldCycles - 1);

  loader_state_e                  state_q;
  logic [Aw-1:0]                  wr_ptr_q;
  logic [Aw:0]                    len_q;
  logic [HcW-1:0]                 hold_q;
  logic                           in_ready_q;
  logic                           prog_loading_q;
  logic                           load_done_q;
  logic                           load_err_q;
  logic [DataDepth-1:0][WordW-1:0] frame_q;

  logic             frame_we;
  logic [WordW-1:0] frame_wdata;
  logic             len_ok;
  logic             last_word;
  logic             full_len;
  logic             last_zero;
  logic             payload_hs;

  assign len_ok    = (load_len_i != '0) && (load_len_i <= LenMax);
  assign last_word = ({1'b0, wr_ptr_q} == (len_q - LenOne));
  assign full_len  = (len_q == LenMax);
  assign last_zero = (wr_ptr_q == PtrMax);

`ifdef GPU_LOADER_CHECKSUM_EN
  logic  cks_phase_q;
  logic  abort_q;
  logic  start_ok;
  xsum_t xsum;

  assign start_ok   = ((state_q == StIdle) || (state_q == StDone)) && load_start_i && len_ok;
  assign payload_hs = (state_q == StLoad) && in_valid_i && !cks_phase_q;

  gpu_loader_xsum u_xsum (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (start_ok),
    .en_i   (payload_hs),
    .data_i (in_data_i),
    .sum_o  (xsum)
  );
`else
  assign payload_hs = (state_q == StLoad) && in_valid_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      len_q          <= '0;
      hold_q         <= '0;
      in_ready_q     <= 1'b0;
      prog_loading_q <= 1'b1;
      load_done_q    <= 1'b0;
      load_err_q     <= 1'b0;
`ifdef GPU_LOADER_CHECKSUM_EN
      cks_phase_q    <= 1'b0;
      abort_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (state_q == StDone) begin
            prog_loading_q <= 1'b0;
            load_done_q    <= 1'b1;
          end
          // An accepted start overrides the DONE outputs and re-halts the gpu.
          if (load_start_i) begin
            if (len_ok) begin
              state_q        <= StLoad;
              len_q          <= load_len_i;
              wr_ptr_q       <= '0;
              in_ready_q     <= 1'b1;
              prog_loading_q <= 1'b1;
              load_done_q    <= 1'b0;
              load_err_q     <= 1'b0;
            end else begin
              load_err_q <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (in_valid_i) begin
`ifdef GPU_LOADER_CHECKSUM_EN
            if (cks_phase_q) begin
              cks_phase_q <= 1'b0;
              in_ready_q  <= 1'b0;
              hold_q      <= '0;
              if (in_data_i == xsum) begin
                state_q <= full_len ? StHold : StZero;
              end else begin
                // Bad checksum: sweep the whole frame back to zero, then park in IDLE.
                load_err_q <= 1'b1;
                abort_q    <= 1'b1;
                wr_ptr_q   <= '0;
                state_q    <= StZero;
              end
            end else begin
              if (last_word) begin
                cks_phase_q <= 1'b1;
              end
              if (!(last_word && full_len)) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
              end
            end
`else
            if (last_word) begin
              in_ready_q <= 1'b0;
              hold_q     <= '0;
              state_q    <= full_len ? StHold : StZero;
            end
            if (!(last_word && full_len)) begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
            end
`endif
          end
        end
        StZero: begin
          if (last_zero) begin
            hold_q <= '0;
`ifdef GPU_LOADER_CHECKSUM_EN
            if (abort_q) begin
              abort_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              state_q <= StHold;
            end
`else
            state_q <= StHold;
`endif
          end else begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
          end
        end
        StHold: begin
          if (hold_q == HoldLast) begin
            state_q <= StDone;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    frame_we    = 1'b0;
    frame_wdata = '0;
    if (state_q == StZero) begin
      frame_we = 1'b1;
    end else if (payload_hs) begin
      frame_we    = 1'b1;
      frame_wdata = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_q <= '0;
    end else if (frame_we) begin
      frame_q[wr_ptr_q] <= frame_wdata;
    end
  end

  assign data_frames_out_o = frame_q;
  assign in_ready_o        = in_ready_q;
  assign prog_loading_o    = prog_loading_q;
  assign load_done_o       = load_done_q;
  assign load_err_o        = load_err_q;

endmodule
